riscv_fetch_buffer: RTL and testbench

Parametrised instruction-fetch front end. It sits between `riscv_memory`'s instruction port and `riscv_decoder`, and replaces hand-driven `iaddr`/`ird` sequencing with an autonomous sequential PC generator. Fetched opcodes are held in a DEPTH-entry prefetch FIFO and handed to the decode stage over a valid/ready handshake. A redirect input supports branches and jumps by flushing the buffer and squashing in-flight reads.

---
 rtl/riscv_fetch_buffer_if.sv | 25 ++
 rtl/riscv_fetch_buffer.sv | 98 +++++++++
 tb/tb_riscv_fetch_buffer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_fetch_buffer_if.sv
// Fetch-buffer bus bundle: instruction-memory port, redirect request and the
// valid/ready handoff to decode. Port suffixes are from the fetch buffer's view.
interface riscv_fetch_buffer_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] iaddr_o;
   logic              ird_o;
   logic [31:0]       irdata_i;
   logic              redirect_i;
   logic [ADDR_W-1:0] redirect_pc_i;
   logic              fetch_valid_o;
   logic [31:0]       fetch_opcode_o;
   logic [ADDR_W-1:0] fetch_pc_o;
   logic              fetch_ready_i;

   modport master (
      output iaddr_o, ird_o, fetch_valid_o, fetch_opcode_o, fetch_pc_o,
      input  irdata_i, redirect_i, redirect_pc_i, fetch_ready_i
   );

   modport slave (
      input  iaddr_o, ird_o, fetch_valid_o, fetch_opcode_o, fetch_pc_o,
      output irdata_i, redirect_i, redirect_pc_i, fetch_ready_i
   );
endinterface

// File: rtl/riscv_fetch_buffer.sv
// Autonomous sequential instruction fetch with a DEPTH-entry {pc, opcode}
// prefetch FIFO, credit-based issue and redirect flush.
module riscv_fetch_buffer #(
   parameter int                DEPTH    = 4,
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   riscv_fetch_buffer_if.master         bus,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
   logic              inflight_q, inflight_d;
   logic              squash_q, squash_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [ADDR_W-1:0] fifo_pc_q [DEPTH];
   logic [31:0]       fifo_op_q [DEPTH];

   logic [CW:0]       credit;
   logic              issue;
   logic              push;
   logic              pop;
   logic              unused_pc_lsb;

   assign unused_pc_lsb = ^bus.redirect_pc_i[1:0];

   // Credits count registered occupancy plus the outstanding read, so a push
   // can never land on a full FIFO without a matching pop.
   always_comb begin
      credit = (CW+1)'(count_q) + (CW+1)'(inflight_q);
      issue  = !reset_i && !bus.redirect_i && (credit < (CW+1)'(DEPTH));
      push   = inflight_q && !squash_q && !bus.redirect_i;
      pop    = (count_q != '0) && bus.fetch_ready_i && !bus.redirect_i;
   end

   always_comb begin
      pc_d          = pc_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      inflight_d    = issue;
      squash_d      = bus.redirect_i;
      inflight_pc_d = issue ? pc_q : inflight_pc_q;
      if (bus.redirect_i) begin
         pc_d     = {bus.redirect_pc_i[ADDR_W-1:2], 2'b00};
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (issue) pc_d = pc_q + ADDR_W'(4);
         if (push)  wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pc_q          <= RESET_PC;
         inflight_pc_q <= '0;
         inflight_q    <= 1'b0;
         squash_q      <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_pc_q <= inflight_pc_d;
         inflight_q    <= inflight_d;
         squash_q      <= squash_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
      end
   end

   // Storage is not reset; entries are only visible through the occupancy count.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_pc_q[wr_ptr_q] <= inflight_pc_q;
         fifo_op_q[wr_ptr_q] <= bus.irdata_i;
      end
   end

   assign bus.iaddr_o        = pc_q;
   assign bus.ird_o          = issue;
   assign bus.fetch_valid_o  = (count_q != '0);
   assign bus.fetch_opcode_o = bus.fetch_valid_o ? fifo_op_q[rd_ptr_q] : 32'h0;
   assign bus.fetch_pc_o     = bus.fetch_valid_o ? fifo_pc_q[rd_ptr_q] : '0;
   assign count_o            = count_q;
endmodule

// File: tb/tb_riscv_fetch_buffer.sv
// Scoreboard bench for riscv_fetch_buffer: directed phases push expected PCs,
// independent monitors compare every accepted head against the queue.
module tb_riscv_fetch_buffer;
   logic       clk = 1'b0;
   logic       rst;
   logic       rst2;
   logic [2:0] cnt;
   logic [2:0] cnt2;
   int         errors = 0;
   int         checks = 0;
   int         acc    = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp2_q[$];

   always #5 clk = ~clk;

   riscv_fetch_buffer_if #(.ADDR_W(32)) bus  ();
   riscv_fetch_buffer_if #(.ADDR_W(32)) bus2 ();

   riscv_fetch_buffer #(.DEPTH(4), .ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
      .clk_i(clk), .reset_i(rst), .bus(bus), .count_o(cnt)
   );
   riscv_fetch_buffer #(.DEPTH(4), .ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) dut2 (
      .clk_i(clk), .reset_i(rst2), .bus(bus2), .count_o(cnt2)
   );

   // Memory contents: odd-multiplier hash, distinct for every word address.
   function automatic logic [31:0] opc(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   always @(posedge clk) begin
      bus.irdata_i  <= bus.ird_o  ? opc(bus.iaddr_o)  : 32'hDEAD_BEEF;
      bus2.irdata_i <= bus2.ird_o ? opc(bus2.iaddr_o) : 32'hDEAD_BEEF;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_stream(input logic [31:0] start, input int n);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
   endtask

   always @(negedge clk) begin
      logic [31:0] e;
      if (!rst && !bus.redirect_i) begin
         chk("count_le_depth", 32'(cnt <= 3'd4), 32'd1);
         if (bus.fetch_valid_o && bus.fetch_ready_i) begin
            if (exp_q.size() == 0) begin
               errors++;
               checks++;
               $display("FAIL unexpected_pop: got pc %h required none", bus.fetch_pc_o);
            end else begin
               e = exp_q.pop_front();
               $display("accept pc=%h op=%h", bus.fetch_pc_o, bus.fetch_opcode_o);
               chk("fetch_pc", bus.fetch_pc_o, e);
               chk("fetch_opcode", bus.fetch_opcode_o, opc(e));
               acc++;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [31:0] e;
      if (!rst2 && bus2.fetch_valid_o && bus2.fetch_ready_i && exp2_q.size() > 0) begin
         e = exp2_q.pop_front();
         $display("accept2 pc=%h op=%h", bus2.fetch_pc_o, bus2.fetch_opcode_o);
         chk("wrap_pc", bus2.fetch_pc_o, e);
         chk("wrap_opcode", bus2.fetch_opcode_o, opc(e));
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish required finish");
      $fatal(1, "timeout");
   end

   initial begin
      int  a0;
      bit  found;
      rst = 1'b1;
      rst2 = 1'b1;
      bus.fetch_ready_i  = 1'b1;
      bus.redirect_i     = 1'b0;
      bus.redirect_pc_i  = 32'h0;
      bus2.fetch_ready_i = 1'b1;
      bus2.redirect_i    = 1'b0;
      bus2.redirect_pc_i = 32'h0;
      exp2_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      tick();
      tick();

      chk("rst_ird", 32'(bus.ird_o), 32'd0);
      chk("rst_iaddr", bus.iaddr_o, 32'h0);
      chk("rst_valid", 32'(bus.fetch_valid_o), 32'd0);
      chk("rst_opcode", bus.fetch_opcode_o, 32'h0);
      chk("rst_pc", bus.fetch_pc_o, 32'h0);
      chk("rst_count", 32'(cnt), 32'd0);

      // Streaming from reset with ready high
      set_stream(32'h0, 64);
      rst = 1'b0;
      rst2 = 1'b0;
      #1;
      chk("first_ird", 32'(bus.ird_o), 32'd1);
      chk("first_iaddr", bus.iaddr_o, 32'h0);
      a0 = acc;
      tick();
      chk("lat_valid_r1", 32'(bus.fetch_valid_o), 32'd0);
      tick();
      chk("lat_valid_r2", 32'(bus.fetch_valid_o), 32'd1);
      chk("lat_pc_r2", bus.fetch_pc_o, 32'h0);
      repeat (8) tick();
      chk("throughput_8", 32'(acc - a0), 32'd8);

      // Backpressure after one accepted fetch
      rst = 1'b1;
      set_stream(32'h0, 64);
      tick();
      rst = 1'b0;
      tick();
      tick();
      tick();
      bus.fetch_ready_i = 1'b0;
      repeat (10) tick();
      chk("bp_count", 32'(cnt), 32'd4);
      chk("bp_ird", 32'(bus.ird_o), 32'd0);
      chk("bp_head_pc", bus.fetch_pc_o, 32'h4);
      bus.fetch_ready_i = 1'b1;
      #1;
      chk("bp_ird_pop_cycle", 32'(bus.ird_o), 32'd0);
      tick();
      chk("bp_ird_resume", 32'(bus.ird_o), 32'd1);
      chk("bp_iaddr_resume", bus.iaddr_o, 32'h14);
      tick();
      tick();
      for (int i = 0; i < 20; i++) begin
         chk("steady_count", 32'(cnt), 32'd2);
         tick();
      end

      // Redirect with FIFO credit-full and one read in flight
      bus.fetch_ready_i = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (cnt == 3'd3 && !bus.ird_o) found = 1'b1;
      end
      chk("reach_full_inflight", 32'(found), 32'd1);
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 32'h43;
      bus.fetch_ready_i = 1'b1;
      set_stream(32'h40, 64);
      #1;
      chk("redir_ird", 32'(bus.ird_o), 32'd0);
      tick();
      bus.redirect_i = 1'b0;
      #1;
      chk("redir_ird_r1", 32'(bus.ird_o), 32'd1);
      chk("redir_iaddr_r1", bus.iaddr_o, 32'h40);
      chk("redir_valid_r1", 32'(bus.fetch_valid_o), 32'd0);
      chk("redir_count_r1", 32'(cnt), 32'd0);
      tick();
      chk("redir_valid_r2", 32'(bus.fetch_valid_o), 32'd0);
      tick();
      chk("redir_valid_r3", 32'(bus.fetch_valid_o), 32'd1);
      chk("redir_pc_r3", bus.fetch_pc_o, 32'h40);
      repeat (6) tick();

      // One-cycle reset mid-stream with a read outstanding
      chk("pre_reset_ird", 32'(bus.ird_o), 32'd1);
      rst = 1'b1;
      set_stream(32'h0, 64);
      tick();
      rst = 1'b0;
      #1;
      chk("mrst_valid", 32'(bus.fetch_valid_o), 32'd0);
      chk("mrst_count", 32'(cnt), 32'd0);
      chk("mrst_ird", 32'(bus.ird_o), 32'd1);
      chk("mrst_iaddr", bus.iaddr_o, 32'h0);
      tick();
      chk("mrst_valid_r1", 32'(bus.fetch_valid_o), 32'd0);
      tick();
      chk("mrst_valid_r2", 32'(bus.fetch_valid_o), 32'd1);
      chk("mrst_pc_r2", bus.fetch_pc_o, 32'h0);
      repeat (5) tick();

      chk("wrap_all_seen", 32'(exp2_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
